// File: rtl/cache_miss_ctrl_if.sv
// Memory-side request/response port of the L1 miss and write-through controller.
// The controller is the master. The data memory is the slave.
interface cache_miss_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_byte;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_byte, mem_re, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_byte, mem_re, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// L1 data-cache miss controller with a FIFO write-through store buffer.
// The buffer always drains ahead of a miss read so that memory sees requests in program order.
module cache_miss_ctrl #(
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addressM,
  input  logic [31:0]       dataM,
  input  logic              LoadM,
  input  logic              memwriteM,
  input  logic              StoreM,
  input  logic              hit,
  output logic              stall,
  output logic              fill_en,
  output logic [31:0]       fill_data,
  cache_miss_ctrl_if.master mem
);
  localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic        is_byte;
    logic [31:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, READ, FILL} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [31:0]       miss_addr;
  wbuf_entry_t       wbuf [WBUF_DEPTH];
  wbuf_entry_t       head;

  logic miss;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic re;
  logic we;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot early.
  always_comb begin
    miss          = LoadM & ~hit;
    full          = (count == CNT_W'(WBUF_DEPTH));
    empty         = (count == '0);
    stall         = (state != IDLE) | ((state == IDLE) & miss) | (memwriteM & full);
    push          = memwriteM & ~stall & ~full;
    head          = wbuf[rd_ptr];
    re            = (state == READ);
    we            = (state != READ) & ~empty;
    pop           = we & mem.mem_ready;
    mem.mem_re    = re;
    mem.mem_we    = we;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_byte  = 1'b0;
    if (re) begin
      mem.mem_addr = miss_addr;
    end else if (we) begin
      mem.mem_addr  = head.addr;
      mem.mem_wdata = head.data;
      mem.mem_byte  = head.is_byte;
    end
  end

  // Buffer storage needs no reset: entries are only observed when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wbuf[wr_ptr] <= '{is_byte: StoreM, addr: addressM, data: dataM};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      miss_addr <= '0;
      fill_en   <= 1'b0;
      fill_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count + CNT_W'(push) - CNT_W'(pop);
      fill_en <= 1'b0;
      case (state)
        IDLE: begin
          if (miss) begin
            miss_addr <= addressM;
            state     <= empty ? READ : DRAIN;
          end
        end
        DRAIN: begin
          if (empty) state <= READ;
        end
        READ: begin
          if (mem.mem_ready) begin
            fill_data <= mem.mem_rdata;
            fill_en   <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed scenarios plus randomized pipeline and memory traffic.
// A queue-based reference model is compared against the DUT on every falling edge.
module tb_cache_miss_ctrl;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addressM;
  logic [31:0] dataM;
  logic        LoadM;
  logic        memwriteM;
  logic        StoreM;
  logic        hit;
  logic        stall;
  logic        fill_en;
  logic [31:0] fill_data;

  cache_miss_ctrl_if mif();

  cache_miss_ctrl #(.WBUF_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .addressM  (addressM),
    .dataM     (dataM),
    .LoadM     (LoadM),
    .memwriteM (memwriteM),
    .StoreM    (StoreM),
    .hit       (hit),
    .stall     (stall),
    .fill_en   (fill_en),
    .fill_data (fill_data),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending stores as a queue plus the progress of one outstanding miss.
  typedef struct packed {
    logic        b;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        wq[$];
  bit          m_busy = 0, m_wait = 0, m_read = 0, m_fill = 0;
  logic [31:0] m_addr = '0, m_fdata = '0;
  bit          e_we, e_stall, pop_m, push_m;
  bit          n_busy, n_wait, n_read, n_fill;
  int          sz;

  always @(negedge clk) begin
    sz      = wq.size();
    e_we    = !m_read && sz > 0;
    e_stall = m_busy || (LoadM && !hit) || (memwriteM && sz == DEPTH);
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_re", 32'(mif.mem_re), 32'(m_read));
      chk("mem_we", 32'(mif.mem_we), 32'(e_we));
      chk("re_we_exclusive", 32'(mif.mem_re & mif.mem_we), 32'd0);
      chk("fill_en", 32'(fill_en), 32'(m_fill));
      if (m_read) chk("read_addr", mif.mem_addr, m_addr);
      if (e_we) begin
        chk("write_addr", mif.mem_addr, wq[0].a);
        chk("write_data", mif.mem_wdata, wq[0].d);
        chk("write_byte", 32'(mif.mem_byte), 32'(wq[0].b));
      end
      if (m_fill) chk("fill_data", fill_data, m_fdata);
    end
    if (rst) begin
      wq.delete();
      m_busy = 0; m_wait = 0; m_read = 0; m_fill = 0;
      m_addr = '0; m_fdata = '0;
    end else begin
      pop_m  = e_we && mif.mem_ready;
      push_m = memwriteM && !e_stall && sz < DEPTH;
      n_busy = m_busy; n_wait = m_wait; n_read = m_read; n_fill = 0;
      if (!m_busy && LoadM && !hit) begin
        n_busy = 1;
        m_addr = addressM;
        if (sz == 0) n_read = 1;
        else         n_wait = 1;
      end
      if (m_wait && sz == 0) begin
        n_wait = 0;
        n_read = 1;
      end
      if (m_read && mif.mem_ready) begin
        m_fdata = mif.mem_rdata;
        n_read  = 0;
        n_fill  = 1;
      end
      if (m_fill) n_busy = 0;
      m_busy = n_busy; m_wait = n_wait; m_read = n_read; m_fill = n_fill;
      if (pop_m)  void'(wq.pop_front());
      if (push_m) wq.push_back('{b: StoreM, a: addressM, d: dataM});
    end
  end

  int          scnt, fcnt, rcyc, sn, wrb, ovl, r;
  bit          got, seen, ps, pf;
  logic [31:0] fd;
  logic [31:0] cap_a[$];
  logic [31:0] cap_d[$];

  initial begin
    rst = 1'b1; addressM = '0; dataM = '0; LoadM = 1'b0; memwriteM = 1'b0;
    StoreM = 1'b0; hit = 1'b1; mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fill_en", 32'(fill_en), 32'd0);
    chk("rst_fill_data", fill_data, 32'd0);
    chk("rst_mem_re", 32'(mif.mem_re), 32'd0);
    chk("rst_mem_we", 32'(mif.mem_we), 32'd0);
    chk("rst_mem_byte", 32'(mif.mem_byte), 32'd0);
    chk("rst_mem_addr", mif.mem_addr, 32'd0);
    chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
    step();

    // Miss refill: memory answers on the third READ cycle
    LoadM = 1'b1; hit = 1'b0; addressM = 32'h40;
    scnt = 0; fcnt = 0; rcyc = 0; fd = '0; got = 0;
    for (int c = 0; c < 8; c++) begin
      if (got) hit = 1'b1;
      if (mif.mem_re) rcyc++;
      mif.mem_ready = mif.mem_re && (rcyc == 3);
      mif.mem_rdata = mif.mem_ready ? 32'hDEADBEEF : $urandom;
      @(negedge clk);
      if (stall) scnt++;
      if (fill_en) begin fcnt++; fd = fill_data; got = 1; end
      step();
    end
    chk("miss_stall_cycles", 32'(scnt), 32'd5);
    chk("miss_fill_pulses", 32'(fcnt), 32'd1);
    chk("miss_fill_data", fd, 32'hDEADBEEF);
    LoadM = 1'b0; mif.mem_ready = 1'b0;

    // Buffered word stores with memory always ready
    hit = 1'b1; mif.mem_ready = 1'b1; sn = 0;
    for (int c = 0; c < 8; c++) begin
      memwriteM = (c < 3); addressM = 32'h10 + 32'(4 * c); dataM = 32'(c + 1); StoreM = 1'b0;
      @(negedge clk);
      if (stall) sn++;
      if (mif.mem_we && mif.mem_ready) begin
        cap_a.push_back(mif.mem_addr);
        cap_d.push_back(mif.mem_wdata);
      end
      step();
    end
    memwriteM = 1'b0;
    chk("stores_no_stall", 32'(sn), 32'd0);
    chk("stores_count", 32'(cap_a.size()), 32'd3);
    for (int i = 0; i < 3 && i < cap_a.size(); i++) begin
      chk("stores_addr_order", cap_a[i], 32'h10 + 32'(4 * i));
      chk("stores_data_order", cap_d[i], 32'(i + 1));
    end

    // Full buffer: memory stalled, fifth store must wait for a pop
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memwriteM = 1'b1; addressM = 32'h100 + 32'(4 * i); dataM = 32'hA0 + 32'(i);
      @(negedge clk);
      chk("full_push_no_stall", 32'(stall), 32'd0);
      step();
    end
    addressM = 32'h110; dataM = 32'hA4;
    @(negedge clk); chk("full_fifth_stall", 32'(stall), 32'd1); step();
    @(negedge clk); chk("full_fifth_hold", 32'(stall), 32'd1); step();
    mif.mem_ready = 1'b1;
    @(negedge clk); chk("full_pop_cycle_stall", 32'(stall), 32'd1); step();
    mif.mem_ready = 1'b0;
    @(negedge clk); chk("full_fifth_pushed", 32'(stall), 32'd0); step();
    memwriteM = 1'b0; mif.mem_ready = 1'b1;
    repeat (6) step();
    mif.mem_ready = 1'b0;

    // Drain before read
    for (int i = 0; i < 2; i++) begin
      memwriteM = 1'b1; addressM = 32'h200 + 32'(4 * i); dataM = 32'hB0 + 32'(i);
      step();
    end
    memwriteM = 1'b0;
    LoadM = 1'b1; hit = 1'b0; addressM = 32'h10;
    wrb = 0; ovl = 0; seen = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      mif.mem_ready = 1'($urandom_range(0, 1));
      mif.mem_rdata = $urandom;
      @(negedge clk);
      if (mif.mem_we && mif.mem_ready && !seen) wrb++;
      if (mif.mem_re) seen = 1;
      if (mif.mem_re && mif.mem_we) ovl++;
      if (fill_en) got = 1;
      step();
    end
    hit = 1'b1; LoadM = 1'b0; mif.mem_ready = 1'b0;
    chk("drain_writes_before_read", 32'(wrb), 32'd2);
    chk("drain_no_overlap", 32'(ovl), 32'd0);
    chk("drain_fill_seen", 32'(got), 32'd1);

    // Byte store
    memwriteM = 1'b1; StoreM = 1'b1; dataM = 32'h12345678; addressM = 32'h23;
    step();
    memwriteM = 1'b0; StoreM = 1'b0;
    @(negedge clk);
    chk("byte_mem_we", 32'(mif.mem_we), 32'd1);
    chk("byte_mem_byte", 32'(mif.mem_byte), 32'd1);
    chk("byte_mem_addr", mif.mem_addr, 32'h23);
    chk("byte_mem_wdata", mif.mem_wdata, 32'h12345678);
    step();
    mif.mem_ready = 1'b1; step();
    mif.mem_ready = 1'b0;

    // Reset during the second READ cycle
    LoadM = 1'b1; hit = 1'b0; addressM = 32'h80;
    step();
    step();
    chk("rst_read_active", 32'(mif.mem_re), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; LoadM = 1'b0; hit = 1'b1;
    @(negedge clk);
    chk("rst_read_mem_re", 32'(mif.mem_re), 32'd0);
    chk("rst_read_stall", 32'(stall), 32'd0);
    chk("rst_read_mem_we", 32'(mif.mem_we), 32'd0);
    step();

    // Reset with stores pending clears the buffer
    memwriteM = 1'b1; addressM = 32'h300; step();
    addressM = 32'h304; step();
    memwriteM = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_buffer_cleared", 32'(mif.mem_we), 32'd0);
    step();

    // Random traffic: a stalled pipeline holds its memory-stage instruction
    ps = 0; pf = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      mif.mem_ready = ($urandom_range(0, 3) != 0);
      mif.mem_rdata = $urandom;
      if (ps) begin
        if (pf) hit = 1'b1;
      end else begin
        r = int'($urandom_range(0, 9));
        LoadM = (r < 4);
        memwriteM = (r >= 4 && r < 7);
        hit = 1'($urandom_range(0, 1));
        addressM = $urandom;
        dataM = $urandom;
        StoreM = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      ps = stall;
      pf = fill_en;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Miss and write-through controller between the L1 data cache and data memory in the memory stage. It detects load misses, stalls the pipeline, fetches the missing word from memory through a ready-handshake port and returns it to the cache as a one-cycle fill. Stores are written through to memory via a small FIFO store buffer, so stores only stall when the buffer is full. The buffer is always drained before a miss read to preserve memory ordering.

## Interface
- `WBUF_DEPTH`, 4: store-buffer entries; power of two, minimum 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addressM`  in  32  memory-stage address.
- `dataM`  in  32  memory-stage store data.
- `LoadM`  in  1  load in memory stage.
- `memwriteM`  in  1  store in memory stage.
- `StoreM`  in  1  byte store (1) vs word store (0); travels with the buffer entry.
- `hit`  in  1  cache hit, combinational from the cache.
- `stall`  out  1  freeze the pipeline up to and including the memory stage.
- `fill_en`  out  1  cache must write `fill_data` into the way it replaces for `addressM`.
- `fill_data`  out  32  refill word, which drives the cache `memIn`.
- `mem_addr`  out  32  memory request address.
- `mem_wdata`  out  32  memory write data.
- `mem_byte`  out  1  byte-write qualifier for `mem_we`.
- `mem_re`  out  1  memory read request.
- `mem_we`  out  1  memory write request.
- `mem_rdata`  in  32  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completes the current request this cycle.

## Operation
- FSM states: IDLE, DRAIN, READ, FILL.
- **IDLE**
  - If `LoadM && !hit` and the buffer is non-empty, go to DRAIN.
  - If `LoadM && !hit` and the buffer is empty, go to READ.
- **DRAIN**: go to READ in the cycle after the buffer count reaches 0.
- **READ**
  - Drive `mem_re=1` and `mem_addr=addressM`.
  - On `mem_ready`, register `mem_rdata` into `fill_data` and go to FILL.
- **FILL**: drive `fill_en=1` for exactly one cycle, then return to IDLE.
- `stall = (state!=IDLE) | (state==IDLE & LoadM & !hit) | (memwriteM & full)`.
- Store push
  - A store is pushed when `memwriteM & !stall & !full`.
  - Entry = {`StoreM`, `addressM`, `dataM`}.
  - `full` and `empty` derive from the registered count only, so a same-cycle pop never admits a push into a full buffer.
- Drain engine
  - When state is not READ and the buffer is non-empty, drive `mem_we=1` with the head entry on `mem_addr`/`mem_wdata`/`mem_byte`.
  - Pop the head on `mem_ready`.
  - Drain runs in IDLE as well as in DRAIN.
- `mem_re` and `mem_we` are never high together.
- A request, once raised, holds its address, data and qualifier stable until `mem_ready`.
- A simultaneous push and pop leaves the count unchanged. Read/write pointers wrap modulo `WBUF_DEPTH`.
- Stores to an address pending in the buffer are ordered FIFO; there is no merging.

## Timing
- Reset: state=IDLE, count=0, pointers=0.
  - `fill_en`, `mem_re`, `mem_we`, `mem_byte` = 0.
  - `fill_data`, `mem_addr`, `mem_wdata` = 0.
  - `stall` is 0 unless its combinational terms fire.
- Reset mid-operation abandons any in-flight read or write and clears the buffer. Memory must tolerate the dropped request.
- Miss latency with the buffer empty and memory ready after N request cycles:
  - `stall` is high from the miss cycle through the FILL cycle, i.e. N+2 cycles.
  - The cache hits in the cycle after FILL.
- Write latency: a push becomes visible as the head in the next cycle, so the earliest `mem_we` is one cycle after the push.
- Outputs to memory are registered or state-decoded. Only `stall` depends combinationally on `hit`, `LoadM`, `memwriteM`.

## Test plan
- **Miss refill**
  - Stimulus: reset; `LoadM=1`, `hit=0`, `addressM=0x40`; memory returns `0xDEADBEEF` with `mem_ready` on the 3rd READ cycle.
  - Response: `stall` high for 5 cycles; `fill_en` for one cycle with `fill_data=0xDEADBEEF`; then stall drops with `hit=1`.
- **Buffered stores**
  - Stimulus: 3 back-to-back word stores to 0x10/0x14/0x18 with data 1/2/3; memory always ready.
  - Response: no stall; `mem_we` issues 0x10, 0x14, 0x18 in order with matching data.
- **Full buffer**
  - Stimulus: `mem_ready=0`; 5 stores.
  - Response: first 4 pushed; 5th holds `stall=1` until a `mem_ready` pops an entry, then is pushed the following cycle.
- **Drain-before-read**
  - Stimulus: 2 pending stores, then a load miss to 0x10.
  - Response: both `mem_we` complete before `mem_re` rises; `mem_re` never overlaps `mem_we`.
- **Byte store**
  - Stimulus: `StoreM=1`, `dataM=0x12345678`, `addressM=0x23`.
  - Response: `mem_byte=1`, `mem_wdata=0x12345678`, `mem_addr=0x23`.
- **Reset in READ**
  - Stimulus: assert `rst` during the 2nd READ cycle.
  - Response: next cycle state IDLE, `mem_re=0`, count 0, `stall=0` with `LoadM=0`.
